// File: rtl/eth_pkg.sv
// ============================================================================
// eth_pkg
// Ethernet/IPv4/UDP header layouts, protocol constants and byte offsets
// shared by the RX header parser and the TX header generator.
// Revision: 1.0
// ============================================================================
`default_nettype none

package eth_pkg;

  typedef struct packed {
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] ethertype;
  } ethernet_header;

  typedef struct packed {
    logic [7:0]  version_ihl;
    logic [7:0]  tos;
    logic [15:0] total_length;
    logic [15:0] identification;
    logic [15:0] flags_fragment;
    logic [7:0]  ttl;
    logic [7:0]  protocol;
    logic [15:0] checksum;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
  } ipv4_header;

  typedef struct packed {
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] length;
    logic [15:0] checksum;
  } udp_header;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HEADER  = 2'd1,
    S_PAYLOAD = 2'd2,
    S_DROP    = 2'd3
  } parse_state_t;

  localparam logic [15:0] ETHERTYPE_IPV4   = 16'h0800;
  localparam logic [7:0]  VERSION_IHL_IPV4 = 8'h45;
  localparam logic [7:0]  PROTO_UDP        = 8'h11;
  localparam logic [15:0] UDP_HEADER_BYTES = 16'd8;
  localparam logic [15:0] UDP_MAX_LENGTH   = 16'd4103;
  localparam int          ETH_HEADER_BYTES = 42;

  localparam logic [5:0] OFF_DST_MAC   = 6'd0;
  localparam logic [5:0] OFF_SRC_MAC   = 6'd6;
  localparam logic [5:0] OFF_ETHERTYPE = 6'd12;
  localparam logic [5:0] OFF_VER_IHL   = 6'd14;
  localparam logic [5:0] OFF_PROTO     = 6'd23;
  localparam logic [5:0] OFF_SRC_IP    = 6'd26;
  localparam logic [5:0] OFF_DST_IP    = 6'd30;
  localparam logic [5:0] OFF_SRC_PORT  = 6'd34;
  localparam logic [5:0] OFF_DST_PORT  = 6'd36;
  localparam logic [5:0] OFF_UDP_LEN   = 6'd38;
  localparam logic [5:0] OFF_LAST      = 6'(ETH_HEADER_BYTES - 1);

endpackage

`default_nettype wire

// File: rtl/eth_header_parse.sv
// ============================================================================
// eth_header_parse
// Parses Ethernet/IPv4/UDP headers from an RX byte stream, filters on the
// local MAC/IP/port and forwards the UDP payload trimmed to the UDP length.
// Revision: 1.0
// ============================================================================
`default_nettype none

module eth_header_parse
  import eth_pkg::*;
#(
  parameter logic [47:0] FPGA_MAC  = 48'he86a64e7e830,
  parameter logic [31:0] FPGA_IP   = 32'hC0A80164,
  parameter logic [15:0] FPGA_PORT = 16'h4567
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        hdr_valid,
  output logic [47:0] src_mac,
  output logic [31:0] src_ip,
  output logic [15:0] src_port,
  output logic [11:0] payload_bytes,
  output logic [15:0] frames_ok,
  output logic [15:0] frames_dropped
);

  parse_state_t r_state;
  logic [5:0]   r_cnt;
  logic         r_match;
  logic [15:0]  r_len;
  logic [47:0]  r_smac;
  logic [31:0]  r_sip;
  logic [15:0]  r_sport;
  logic [11:0]  r_pcnt;

  logic         w_in_payload;
  logic         w_accept;
  logic [5:0]   w_idx;
  logic [15:0]  w_len;
  logic [11:0]  w_plen;
  logic         w_byte_ok;
  logic         w_match_next;

  assign w_in_payload  = (r_state == S_PAYLOAD);
  assign s_axis_tready = w_in_payload ? m_axis_tready : 1'b1;
  assign w_accept      = s_axis_tvalid & s_axis_tready;
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tvalid = w_in_payload & s_axis_tvalid;
  assign m_axis_tlast  = w_in_payload & ((r_pcnt == 12'd1) | s_axis_tlast);

  // The byte taken in IDLE is header byte 0.
  assign w_idx        = (r_state == S_IDLE) ? 6'd0 : r_cnt;
  assign w_len        = {r_len[7:0], s_axis_tdata};
  assign w_plen       = 12'(r_len - UDP_HEADER_BYTES);
  assign w_match_next = ((r_state == S_IDLE) | r_match) & w_byte_ok;

  always_comb begin
    w_byte_ok = 1'b1;
    case (w_idx)
      OFF_DST_MAC:             w_byte_ok = (s_axis_tdata == FPGA_MAC[47:40]);
      6'(OFF_DST_MAC + 1):     w_byte_ok = (s_axis_tdata == FPGA_MAC[39:32]);
      6'(OFF_DST_MAC + 2):     w_byte_ok = (s_axis_tdata == FPGA_MAC[31:24]);
      6'(OFF_DST_MAC + 3):     w_byte_ok = (s_axis_tdata == FPGA_MAC[23:16]);
      6'(OFF_DST_MAC + 4):     w_byte_ok = (s_axis_tdata == FPGA_MAC[15:8]);
      6'(OFF_DST_MAC + 5):     w_byte_ok = (s_axis_tdata == FPGA_MAC[7:0]);
      OFF_ETHERTYPE:           w_byte_ok = (s_axis_tdata == ETHERTYPE_IPV4[15:8]);
      6'(OFF_ETHERTYPE + 1):   w_byte_ok = (s_axis_tdata == ETHERTYPE_IPV4[7:0]);
      OFF_VER_IHL:             w_byte_ok = (s_axis_tdata == VERSION_IHL_IPV4);
      OFF_PROTO:               w_byte_ok = (s_axis_tdata == PROTO_UDP);
      OFF_DST_IP:              w_byte_ok = (s_axis_tdata == FPGA_IP[31:24]);
      6'(OFF_DST_IP + 1):      w_byte_ok = (s_axis_tdata == FPGA_IP[23:16]);
      6'(OFF_DST_IP + 2):      w_byte_ok = (s_axis_tdata == FPGA_IP[15:8]);
      6'(OFF_DST_IP + 3):      w_byte_ok = (s_axis_tdata == FPGA_IP[7:0]);
      OFF_DST_PORT:            w_byte_ok = (s_axis_tdata == FPGA_PORT[15:8]);
      6'(OFF_DST_PORT + 1):    w_byte_ok = (s_axis_tdata == FPGA_PORT[7:0]);
      6'(OFF_UDP_LEN + 1):     w_byte_ok = (w_len >= UDP_HEADER_BYTES) &&
                                           (w_len <= UDP_MAX_LENGTH);
      default:                 w_byte_ok = 1'b1;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state        <= S_IDLE;
      r_cnt          <= 6'd0;
      r_match        <= 1'b1;
      r_len          <= 16'd0;
      r_smac         <= 48'd0;
      r_sip          <= 32'd0;
      r_sport        <= 16'd0;
      r_pcnt         <= 12'd0;
      hdr_valid      <= 1'b0;
      src_mac        <= 48'd0;
      src_ip         <= 32'd0;
      src_port       <= 16'd0;
      payload_bytes  <= 12'd0;
      frames_ok      <= 16'd0;
      frames_dropped <= 16'd0;
    end else begin
      hdr_valid <= 1'b0;
      case (r_state)
        S_IDLE, S_HEADER: begin
          if (w_accept) begin
            r_match <= w_match_next;
            r_cnt   <= w_idx + 6'd1;
            if (w_idx >= OFF_SRC_MAC && w_idx < OFF_ETHERTYPE)
              r_smac <= {r_smac[39:0], s_axis_tdata};
            if (w_idx >= OFF_SRC_IP && w_idx < OFF_DST_IP)
              r_sip <= {r_sip[23:0], s_axis_tdata};
            if (w_idx >= OFF_SRC_PORT && w_idx < OFF_DST_PORT)
              r_sport <= {r_sport[7:0], s_axis_tdata};
            if (w_idx >= OFF_UDP_LEN && w_idx < 6'(OFF_UDP_LEN + 2))
              r_len <= w_len;

            if (w_idx == OFF_LAST) begin
              r_cnt <= 6'd0;
              if (w_match_next) begin
                hdr_valid     <= 1'b1;
                frames_ok     <= frames_ok + 16'd1;
                src_mac       <= r_smac;
                src_ip        <= r_sip;
                src_port      <= r_sport;
                payload_bytes <= w_plen;
                r_pcnt        <= w_plen;
                if (s_axis_tlast)
                  r_state <= S_IDLE;
                else if (w_plen == 12'd0)
                  r_state <= S_DROP;
                else
                  r_state <= S_PAYLOAD;
              end else begin
                frames_dropped <= frames_dropped + 16'd1;
                r_state        <= s_axis_tlast ? S_IDLE : S_DROP;
              end
            end else if (s_axis_tlast) begin
              // Runt: frame ended inside the header.
              frames_dropped <= frames_dropped + 16'd1;
              r_cnt          <= 6'd0;
              r_state        <= S_IDLE;
            end else begin
              r_state <= S_HEADER;
            end
          end
        end

        S_PAYLOAD: begin
          if (w_accept) begin
            r_pcnt <= r_pcnt - 12'd1;
            if (r_pcnt == 12'd1) begin
              r_state <= s_axis_tlast ? S_IDLE : S_DROP;
            end else if (s_axis_tlast) begin
              frames_dropped <= frames_dropped + 16'd1;
              r_state        <= S_IDLE;
            end
          end
        end

        default: begin
          if (w_accept && s_axis_tlast)
            r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_eth_header_parse.sv
// ============================================================================
// tb_eth_header_parse
// Directed self-checking bench for eth_header_parse.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_eth_header_parse;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic        hdr_valid;
  logic [47:0] src_mac;
  logic [31:0] src_ip;
  logic [15:0] src_port;
  logic [11:0] payload_bytes;
  logic [15:0] frames_ok;
  logic [15:0] frames_dropped;

  int          errors = 0;
  int          checks = 0;
  int          hdr_cnt = 0;
  int          hdr_base;
  int          last_cycles;
  int          cyc = 0;
  bit          pat_mode = 1'b0;
  logic [3:0]  pat = 4'b1001;
  logic [7:0]  tx_q[$];
  logic [8:0]  rx_q[$];

  always #5 aclk = ~aclk;

  eth_header_parse dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .hdr_valid     (hdr_valid),
    .src_mac       (src_mac),
    .src_ip        (src_ip),
    .src_port      (src_port),
    .payload_bytes (payload_bytes),
    .frames_ok     (frames_ok),
    .frames_dropped(frames_dropped)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge aclk) begin
    if (aresetn) begin
      if (m_tvalid && m_tready) rx_q.push_back({m_tlast, m_tdata});
      if (hdr_valid) hdr_cnt++;
      if (m_tvalid) check("tready_mirror", 64'(s_tready), 64'(m_tready));
    end
  end

  // Header to MAC e8:6a:64:e7:e8:30, IP 192.168.1.100, from 02:11:22:33:44:55,
  // 192.168.1.10:0x1234. Payload bytes are A0+k, pad bytes are 00.
  task automatic build(input logic [15:0] dport, input logic [15:0] ulen,
                       input int npay, input int npad, input int keep);
    logic [7:0] hdr [42];
    hdr = '{8'he8, 8'h6a, 8'h64, 8'he7, 8'he8, 8'h30,
            8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55,
            8'h08, 8'h00, 8'h45, 8'h00, 8'h00, 8'h2e,
            8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h11,
            8'h00, 8'h00, 8'hc0, 8'ha8, 8'h01, 8'h0a,
            8'hc0, 8'ha8, 8'h01, 8'h64, 8'h12, 8'h34,
            dport[15:8], dport[7:0], ulen[15:8], ulen[7:0],
            8'h00, 8'h00};
    tx_q.delete();
    for (int k = 0; k < 42; k++) tx_q.push_back(hdr[k]);
    for (int k = 0; k < npay; k++) tx_q.push_back(8'(8'ha0 + k));
    for (int k = 0; k < npad; k++) tx_q.push_back(8'h00);
    if (keep > 0) while (tx_q.size() > keep) void'(tx_q.pop_back());
  endtask

  task automatic send_frame(input int stop_at);
    int  i = 0;
    int  n = tx_q.size();
    logic acc;
    last_cycles = 0;
    while (i < n && (stop_at < 0 || i < stop_at)) begin
      s_tvalid = 1'b1;
      s_tdata  = tx_q[i];
      s_tlast  = (i == n - 1);
      m_tready = pat_mode ? pat[cyc % 4] : 1'b1;
      cyc++;
      @(negedge aclk);
      acc = s_tready;
      @(posedge aclk);
      #1;
      if (acc) i++;
      last_cycles++;
      if (last_cycles > 500) begin
        check("send_timeout", 64'(i), 64'(n));
        break;
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
  endtask

  task automatic settle();
    repeat (2) @(posedge aclk);
    #1;
  endtask

  task automatic check_payload(input string tag, input int n);
    check({tag, "_count"}, 64'(rx_q.size()), 64'(n));
    for (int k = 0; k < n && k < rx_q.size(); k++)
      check({tag, "_byte"}, 64'(rx_q[k]), 64'({(k == n - 1), 8'(8'ha0 + k)}));
  endtask

  initial begin
    aresetn  = 1'b0;
    s_tdata  = 8'h00;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_m_tvalid", 64'(m_tvalid), 64'(0));
    check("rst_hdr_valid", 64'(hdr_valid), 64'(0));
    check("rst_frames_ok", 64'(frames_ok), 64'(0));
    check("rst_frames_dropped", 64'(frames_dropped), 64'(0));
    check("rst_payload_bytes", 64'(payload_bytes), 64'(0));
    check("rst_src_mac", 64'(src_mac), 64'(0));
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    // Valid frame, 10-byte payload
    hdr_base = hdr_cnt;
    rx_q.delete();
    build(16'h4567, 16'd18, 10, 0, 0);
    send_frame(-1);
    settle();
    check("t1_hdr_pulses", 64'(hdr_cnt - hdr_base), 64'(1));
    check("t1_payload_bytes", 64'(payload_bytes), 64'(10));
    check("t1_src_mac", 64'(src_mac), 64'h021122334455);
    check("t1_src_ip", 64'(src_ip), 64'hc0a8010a);
    check("t1_src_port", 64'(src_port), 64'h1234);
    check_payload("t1", 10);
    check("t1_frames_ok", 64'(frames_ok), 64'(1));
    check("t1_frames_dropped", 64'(frames_dropped), 64'(0));

    // 4-byte payload padded to 60 bytes
    hdr_base = hdr_cnt;
    rx_q.delete();
    build(16'h4567, 16'd12, 4, 14, 0);
    send_frame(-1);
    settle();
    check("t2_hdr_pulses", 64'(hdr_cnt - hdr_base), 64'(1));
    check("t2_payload_bytes", 64'(payload_bytes), 64'(4));
    check_payload("t2", 4);
    check("t2_cycles", 64'(last_cycles), 64'(60));
    check("t2_frames_ok", 64'(frames_ok), 64'(2));
    check("t2_frames_dropped", 64'(frames_dropped), 64'(0));

    // Wrong destination port, then a valid frame
    hdr_base = hdr_cnt;
    rx_q.delete();
    build(16'h4568, 16'd18, 10, 0, 0);
    send_frame(-1);
    settle();
    check("t3_hdr_pulses", 64'(hdr_cnt - hdr_base), 64'(0));
    check("t3_rx_count", 64'(rx_q.size()), 64'(0));
    check("t3_frames_dropped", 64'(frames_dropped), 64'(1));
    check("t3_frames_ok", 64'(frames_ok), 64'(2));
    hdr_base = hdr_cnt;
    build(16'h4567, 16'd18, 10, 0, 0);
    send_frame(-1);
    settle();
    check("t3b_hdr_pulses", 64'(hdr_cnt - hdr_base), 64'(1));
    check_payload("t3b", 10);
    check("t3b_frames_ok", 64'(frames_ok), 64'(3));

    // 20-byte runt, then a valid frame
    hdr_base = hdr_cnt;
    rx_q.delete();
    build(16'h4567, 16'd18, 10, 0, 20);
    send_frame(-1);
    settle();
    check("t4_hdr_pulses", 64'(hdr_cnt - hdr_base), 64'(0));
    check("t4_frames_dropped", 64'(frames_dropped), 64'(2));
    check("t4_rx_count", 64'(rx_q.size()), 64'(0));
    build(16'h4567, 16'd18, 10, 0, 0);
    send_frame(-1);
    settle();
    check("t4b_hdr_pulses", 64'(hdr_cnt - hdr_base), 64'(1));
    check_payload("t4b", 10);
    check("t4b_frames_ok", 64'(frames_ok), 64'(4));

    // Backpressure pattern 1,0,0,1 on m_axis_tready
    hdr_base = hdr_cnt;
    rx_q.delete();
    pat_mode = 1'b1;
    build(16'h4567, 16'd18, 10, 0, 0);
    send_frame(-1);
    pat_mode = 1'b0;
    settle();
    check("t5_hdr_pulses", 64'(hdr_cnt - hdr_base), 64'(1));
    check_payload("t5", 10);
    check("t5_frames_ok", 64'(frames_ok), 64'(5));
    check("t5_frames_dropped", 64'(frames_dropped), 64'(2));

    // Reset while payload byte 3 is presented
    rx_q.delete();
    build(16'h4567, 16'd18, 10, 0, 0);
    send_frame(45);
    s_tvalid = 1'b1;
    s_tdata  = tx_q[45];
    #1;
    check("t6_pre_rst_tvalid", 64'(m_tvalid), 64'(1));
    aresetn = 1'b0;
    #1;
    check("t6_rst_tvalid", 64'(m_tvalid), 64'(0));
    check("t6_rst_frames_ok", 64'(frames_ok), 64'(0));
    check("t6_rst_frames_dropped", 64'(frames_dropped), 64'(0));
    check("t6_rst_payload_bytes", 64'(payload_bytes), 64'(0));
    s_tvalid = 1'b0;
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    hdr_base = hdr_cnt;
    rx_q.delete();
    build(16'h4567, 16'd18, 10, 0, 0);
    send_frame(-1);
    settle();
    check("t6b_hdr_pulses", 64'(hdr_cnt - hdr_base), 64'(1));
    check_payload("t6b", 10);
    check("t6b_frames_ok", 64'(frames_ok), 64'(1));
    check("t6b_frames_dropped", 64'(frames_dropped), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
